altram_sdram_ctrl: RTL and testbench

ALTRAM_SDRAM_CTRL -- requirements
Module: altram_sdram_ctrl

---
 rtl/altram_sdram_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_altram_sdram_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/altram_sdram_ctrl.sv
// rtl/altram_sdram_ctrl.sv - single-port SDRAM controller for the 68000 altram window (define ALTRAM_CL3_EN for CAS latency 3)
module altram_sdram_ctrl #(
  parameter int INIT_WAIT        = 13000,
  parameter int REFRESH_INTERVAL = 480
) (
  input  logic        CLKOSC,
  input  logic        RST,
  input  logic        ACCESS,
  input  logic        UDS,
  input  logic        LDS,
  input  logic        RW,
  input  logic [23:1] A,
  output logic        VALID,
  output logic        WTERM,
  output logic [12:0] MA,
  output logic [1:0]  BA,
  output logic [1:0]  DQM,
  output logic        RAS,
  output logic        CAS,
  output logic        RAMWE
);

`ifdef ALTRAM_CL3_EN
  localparam int          CL       = 3;
  localparam logic [12:0] MRS_MODE = 13'h230;
`else
  localparam int          CL       = 2;
  localparam logic [12:0] MRS_MODE = 13'h220;
`endif

  localparam int CW  = (INIT_WAIT > 8) ? $clog2(INIT_WAIT) : 3;
  localparam int RCW = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_MRS = 3'b000;

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_TRP, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS, S_INIT_MRD,
    S_IDLE, S_ACT, S_RCD, S_RD, S_CLW, S_WR, S_DONE, S_TRP, S_REF
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [2:0]       sync1, sync2;
  logic             access_s, uds_s, lds_s;
  logic             rd_l;
  logic [23:1]      addr_l;
  logic [RCW-1:0]   ref_cnt;
  logic             ref_pend;
  logic             in_init;
  logic             ref_done;
  logic [2:0]       cmd;

  assign access_s = sync2[2];
  assign uds_s    = sync2[1];
  assign lds_s    = sync2[0];
  assign in_init  = (state inside {S_INIT_WAIT, S_INIT_PRE, S_INIT_TRP, S_INIT_REF1,
                                   S_INIT_REF2, S_INIT_MRS, S_INIT_MRD});
  assign ref_done = (state == S_REF) && (cnt == CW'(6));

  // Two-flop synchroniser for the strobes coming from the 68000 clock domain
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
    end else begin
      sync1 <= {ACCESS, UDS, LDS};
      sync2 <= sync1;
    end
  end

  // State register; cnt measures time spent in the current state
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      state <= S_INIT_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= (state_next == state) ? cnt + CW'(1) : '0;
    end
  end

  // Next-state decision; refresh is checked before any new access
  always_comb begin
    state_next = state;
    case (state)
      S_INIT_WAIT: if (cnt == CW'(INIT_WAIT - 1)) state_next = S_INIT_PRE;
      S_INIT_PRE:  state_next = S_INIT_TRP;
      S_INIT_TRP:  if (cnt == CW'(1)) state_next = S_INIT_REF1;
      S_INIT_REF1: if (cnt == CW'(6)) state_next = S_INIT_REF2;
      S_INIT_REF2: if (cnt == CW'(6)) state_next = S_INIT_MRS;
      S_INIT_MRS:  state_next = S_INIT_MRD;
      S_INIT_MRD:  if (cnt == CW'(1)) state_next = S_IDLE;
      S_IDLE: begin
        if (ref_pend)
          state_next = S_REF;
        else if (!access_s && (RW || !uds_s || !lds_s))
          state_next = S_ACT;
      end
      S_ACT:  state_next = S_RCD;
      S_RCD:  state_next = rd_l ? S_RD : S_WR;
      S_RD:   state_next = S_CLW;
      S_CLW:  if (cnt == CW'(CL - 2)) state_next = S_DONE;
      S_WR:   state_next = S_DONE;
      S_DONE: if (access_s) state_next = S_TRP;
      S_TRP:  if (cnt == CW'(1)) state_next = S_IDLE;
      S_REF:  if (ref_done) state_next = S_IDLE;
      default: state_next = S_INIT_WAIT;
    endcase
  end

  // Capture direction and address when an access is accepted
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      rd_l   <= 1'b0;
      addr_l <= '0;
    end else if (state == S_IDLE && state_next == S_ACT) begin
      rd_l   <= RW;
      addr_l <= A;
    end
  end

  // Refresh timer; a pending flag absorbs expiries until the REF has run
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      ref_cnt  <= RCW'(REFRESH_INTERVAL - 1);
      ref_pend <= 1'b0;
    end else if (in_init) begin
      ref_cnt  <= RCW'(REFRESH_INTERVAL - 1);
      ref_pend <= 1'b0;
    end else begin
      if (ref_cnt == '0) begin
        ref_cnt  <= RCW'(REFRESH_INTERVAL - 1);
        ref_pend <= 1'b1;
      end else begin
        ref_cnt <= ref_cnt - RCW'(1);
        if (ref_done) ref_pend <= 1'b0;
      end
    end
  end

  // SDRAM command, address and handshake outputs decoded from the state
  always_comb begin
    cmd   = CMD_NOP;
    MA    = '0;
    BA    = '0;
    DQM   = 2'b11;
    VALID = 1'b1;
    WTERM = 1'b1;
    case (state)
      S_INIT_PRE: begin
        cmd    = CMD_PRE;
        MA[10] = 1'b1;
      end
      S_INIT_REF1, S_INIT_REF2, S_REF: if (cnt == '0) cmd = CMD_REF;
      S_INIT_MRS: begin
        cmd = CMD_MRS;
        MA  = MRS_MODE;
      end
      S_ACT: begin
        cmd = CMD_ACT;
        MA  = addr_l[22:10];
        BA  = {1'b0, addr_l[23]};
      end
      S_RD: begin
        cmd = CMD_RD;
        MA  = {2'b00, 1'b1, 1'b0, addr_l[9:1]};
        BA  = {1'b0, addr_l[23]};
        DQM = 2'b00;
      end
      S_CLW: DQM = 2'b00;
      S_WR: begin
        cmd = CMD_WR;
        MA  = {2'b00, 1'b1, 1'b0, addr_l[9:1]};
        BA  = {1'b0, addr_l[23]};
        DQM = {uds_s, lds_s};
      end
      S_DONE: begin
        VALID = ~rd_l;
        WTERM = rd_l;
      end
      default: cmd = CMD_NOP;
    endcase
  end

  assign {RAS, CAS, RAMWE} = cmd;

endmodule

// File: tb/tb_altram_sdram_ctrl.sv
// tb/tb_altram_sdram_ctrl.sv - scoreboard bench for altram_sdram_ctrl
module tb_altram_sdram_ctrl;

`ifdef ALTRAM_CL3_EN
  localparam int          CL      = 3;
  localparam logic [12:0] MRS_EXP = 13'h230;
`else
  localparam int          CL      = 2;
  localparam logic [12:0] MRS_EXP = 13'h220;
`endif
  localparam int RI  = 64;
  localparam int RI2 = 8;

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_MRS = 3'b000;

  logic        clk, rst_n, access, uds, lds, rw;
  logic [23:1] a;
  logic        valid, wterm, ras, cas, ramwe;
  logic [12:0] ma;
  logic [1:0]  ba, dqm;
  logic        r_valid, r_wterm, r_ras, r_cas, r_we;
  logic [12:0] r_ma;
  logic [1:0]  r_ba, r_dqm;

  altram_sdram_ctrl #(.INIT_WAIT(16), .REFRESH_INTERVAL(RI)) dut (
    .CLKOSC(clk), .RST(rst_n), .ACCESS(access), .UDS(uds), .LDS(lds), .RW(rw), .A(a),
    .VALID(valid), .WTERM(wterm), .MA(ma), .BA(ba), .DQM(dqm),
    .RAS(ras), .CAS(cas), .RAMWE(ramwe)
  );

  altram_sdram_ctrl #(.INIT_WAIT(16), .REFRESH_INTERVAL(RI2)) dut_ref (
    .CLKOSC(clk), .RST(rst_n), .ACCESS(1'b1), .UDS(1'b1), .LDS(1'b1), .RW(1'b1), .A(23'h0),
    .VALID(r_valid), .WTERM(r_wterm), .MA(r_ma), .BA(r_ba), .DQM(r_dqm),
    .RAS(r_ras), .CAS(r_cas), .RAMWE(r_we)
  );

  typedef struct {
    logic        rd;
    logic [1:0]  ba;
    logic [12:0] row;
    logic [8:0]  col;
    logic [1:0]  dqm;
  } txn_t;

  typedef struct {
    int          c;
    logic [2:0]  cmd;
    logic [12:0] ma;
  } ev_t;

  txn_t exp_q[$];
  ev_t  cmd_log[$];
  int   ref2_q[$];

  int   n_checks = 0, n_errors = 0;
  int   cyc = 0, rel_cyc = 0;
  int   act_count = 0, ref_count = 0, done_cnt = 0, rel_cnt = 0;
  int   act_cyc = 0, rw_cyc = 0, acc_rise_cyc = 0;
  int   last_act_cyc = 0, last_ref_cyc = 0, last_valid_cyc = 0;
  int   anomaly2 = 0;
  logic ref2_freeze = 1'b0;
  txn_t cur;
  logic have_cur = 1'b0;
  logic pv = 1'b1, pw = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Main monitor: pops the scoreboard on ACT and checks the rest of the access
  always @(negedge clk) begin
    logic [2:0] c;
    c = {ras, cas, ramwe};
    if (!rst_n) begin
      have_cur = 1'b0;
      pv = 1'b1;
      pw = 1'b1;
    end else begin
      if (c != CMD_NOP) cmd_log.push_back('{cyc, c, ma});
      if (c == CMD_REF) begin
        ref_count++;
        last_ref_cyc = cyc;
      end
      if (c == CMD_ACT) begin
        act_count++;
        last_act_cyc = cyc;
        act_cyc = cyc;
        if (exp_q.size() == 0) check("act_expected", 0, 1);
        else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          check("act_ba", ba, cur.ba);
          check("act_row", ma, cur.row);
        end
      end
      if (c == CMD_RD || c == CMD_WR) begin
        rw_cyc = cyc;
        if (!have_cur) check("rw_expected", 0, 1);
        else begin
          check("rw_dir", c == CMD_RD, cur.rd);
          check("rw_col", ma[8:0], cur.col);
          check("rw_autopre", ma[10], 1);
          check("rw_ba", ba, cur.ba);
          check("rw_dqm", dqm, cur.dqm);
          check("rw_after_act", cyc - act_cyc, 2);
        end
      end
      if (!valid || !wterm) check("vw_excl", valid | wterm, 1);
      if (pv && !valid) begin
        check("valid_is_read", cur.rd, 1);
        check("valid_lat", cyc - rw_cyc, CL);
        last_valid_cyc = cyc;
        done_cnt++;
      end
      if (pw && !wterm) begin
        check("wterm_is_write", cur.rd, 0);
        check("wterm_lat", cyc - rw_cyc, 1);
        done_cnt++;
      end
      if ((!pv && valid) || (!pw && wterm)) begin
        check("release_lat", cyc - acc_rise_cyc, 3);
        rel_cnt++;
      end
      pv = valid;
      pw = wterm;
    end
  end

  // Refresh-only instance: record REF spacing once it reaches IDLE
  always @(negedge clk) begin
    if (rst_n && !ref2_freeze && (cyc > rel_cyc + 35)) begin
      if ({r_ras, r_cas, r_we} == CMD_REF && ref2_q.size() < 8) ref2_q.push_back(cyc);
      if (!r_valid || !r_wterm || r_ma != 13'h0 || r_ba != 2'b00 || r_dqm != 2'b11) anomaly2++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd"}, {ras, cas, ramwe}, CMD_NOP);
    check({tag, "_ma"}, ma, 0);
    check({tag, "_ba"}, ba, 0);
    check({tag, "_dqm"}, dqm, 2'b11);
    check({tag, "_valid"}, valid, 1);
    check({tag, "_wterm"}, wterm, 1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    rel_cyc = cyc;
    cmd_log.delete();
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic check_init();
    check("init_len", cmd_log.size(), 4);
    if (cmd_log.size() >= 4) begin
      check("init_pre_cyc", cmd_log[0].c - rel_cyc, 16);
      check("init_pre_cmd", cmd_log[0].cmd, CMD_PRE);
      check("init_pre_ma", cmd_log[0].ma, 13'h400);
      check("init_ref1_cyc", cmd_log[1].c - rel_cyc, 19);
      check("init_ref1_cmd", cmd_log[1].cmd, CMD_REF);
      check("init_ref2_cyc", cmd_log[2].c - rel_cyc, 26);
      check("init_ref2_cmd", cmd_log[2].cmd, CMD_REF);
      check("init_mrs_cyc", cmd_log[3].c - rel_cyc, 33);
      check("init_mrs_cmd", cmd_log[3].cmd, CMD_MRS);
      check("init_mrs_ma", cmd_log[3].ma, MRS_EXP);
    end
  endtask

  task automatic push_and_drive(input logic rd_i, input logic [23:0] baddr, input logic u, input logic l);
    txn_t t;
    t.rd  = rd_i;
    t.ba  = {1'b0, baddr[23]};
    t.row = baddr[22:10];
    t.col = baddr[9:1];
    t.dqm = rd_i ? 2'b00 : {u, l};
    exp_q.push_back(t);
    rw = rd_i;
    a = baddr[23:1];
    access = 1'b0;
    if (rd_i) begin
      uds = u;
      lds = l;
    end
  endtask

  task automatic wait_done_release(input string tag);
    int d0, r0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done"}, done_cnt != d0, 1);
    @(posedge clk);
    #1;
    r0 = rel_cnt;
    access = 1'b1;
    uds = 1'b1;
    lds = 1'b1;
    acc_rise_cyc = cyc;
    n = 0;
    while (rel_cnt == r0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_released"}, rel_cnt != r0, 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_access(input string tag, input logic rd_i, input logic [23:0] baddr,
                           input logic u, input logic l, input int strobe_dly);
    int a0;
    @(posedge clk);
    #1;
    a0 = act_count;
    push_and_drive(rd_i, baddr, u, l);
    if (!rd_i) begin
      uds = 1'b1;
      lds = 1'b1;
      if (strobe_dly > 0) begin
        repeat (strobe_dly) @(posedge clk);
        #1;
        check({tag, "_no_act_before_strobe"}, act_count - a0, 0);
      end
      uds = u;
      lds = l;
    end
    wait_done_release(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, r0, tgt, a0;
    rst_n = 1'b0;
    access = 1'b1;
    uds = 1'b1;
    lds = 1'b1;
    rw = 1'b1;
    a = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_ref_inst_valid", {r_valid, r_wterm}, 2'b11);

    release_reset();
    check_init();

    do_access("rd_123456", 1'b1, 24'h123456, 1'b0, 1'b0, 0);
    do_access("wr_upper", 1'b0, 24'h2468AC, 1'b0, 1'b1, 4);
    do_access("rd_bank1", 1'b1, 24'h800002, 1'b0, 1'b0, 0);
    do_access("wr_both", 1'b0, 24'h00FFFE, 1'b0, 1'b0, 2);
    do_access("wr_lower", 1'b0, 24'hFFFC00, 1'b1, 1'b0, 0);

    // Access request lands on the same IDLE cycle as a refresh request
    r0 = ref_count;
    n = 0;
    while (ref_count < r0 + 2 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("coll_ref_seen", ref_count >= r0 + 2, 1);
    tgt = last_ref_cyc + RI - 3;
    n = 0;
    while (cyc < tgt && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("coll_aligned", cyc, tgt);
    push_and_drive(1'b1, 24'hFFFFFE, 1'b0, 1'b0);
    wait_done_release("coll");
    check("coll_ref_cyc", last_ref_cyc, tgt + 3);
    check("coll_act_gap", last_act_cyc - last_ref_cyc, 8);
    check("coll_valid_gap", last_valid_cyc - last_act_cyc, 2 + CL);

    ref2_freeze = 1'b1;
    check("ref2_count", ref2_q.size(), 8);
    for (int i = 1; i < ref2_q.size(); i++)
      check($sformatf("ref2_gap%0d", i), ref2_q[i] - ref2_q[i-1], RI2);
    check("ref2_idle_outputs", anomaly2, 0);

    // Reset arrives while the controller sits in RCD
    @(posedge clk);
    #1;
    a0 = act_count;
    push_and_drive(1'b1, 24'h0ABCDE, 1'b0, 1'b0);
    n = 0;
    while (act_count == a0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rcd_act_seen", act_count != a0, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rcd_reset");
    access = 1'b1;
    uds = 1'b1;
    lds = 1'b1;
    repeat (3) @(posedge clk);
    release_reset();
    check_init();
    do_access("post_reset_wr", 1'b0, 24'h555554, 1'b1, 1'b0, 1);

    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
